memory_access: RTL

Memory-access stage of the 16-bit-instruction pipeline, sitting between execute and the write-back/fetch stage. It splits 32-bit loads and stores into two halfword transactions on the 16-bit data-memory port. It also handles byte and halfword accesses, and rejects misaligned accesses. While a word access is in progress it stalls upstream, and it presents registered per-beat control to write-back, which assembles loaded words from the raw memory read data.

---
 rtl/memory_access_if.sv | 17 +
 rtl/memory_access.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/memory_access_if.sv
// Data-memory port of the memory-access stage: 16-bit halfword bus with
// byte enables and separate read/write strobes.
interface memory_access_if;
    logic [31:0] mem_addr_o;
    logic [15:0] mem_wdata_o;
    logic [1:0]  mem_be_o;
    logic        mem_re_o;
    logic        mem_we_o;

    modport master (
        output mem_addr_o, mem_wdata_o, mem_be_o, mem_re_o, mem_we_o
    );

    modport slave (
        input mem_addr_o, mem_wdata_o, mem_be_o, mem_re_o, mem_we_o
    );
endinterface

// File: rtl/memory_access.sv
// Memory-access stage: splits word loads/stores into two halfword beats on a
// 16-bit data-memory port, handles byte/halfword ops and drops misaligned ones.
module memory_access (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   ex_valid_i,
    input  logic [31:0]            ex_alu_result_i,
    input  logic [31:0]            ex_store_data_i,
    input  logic                   ex_mem_read_i,
    input  logic                   ex_mem_write_i,
    input  logic [1:0]             ex_size_i,
    input  logic [3:0]             ex_rd_i,
    input  logic                   ex_reg_write_i,
    memory_access_if.master        mem,
    output logic                   stall_o,
    output logic                   wb_valid_o,
    output logic [31:0]            wb_data_calc_o,
    output logic                   wb_mem_to_reg_o,
    output logic                   wb_last_o,
    output logic [3:0]             wb_rd_o,
    output logic                   wb_reg_write_o,
    output logic                   misalign_o
);

    typedef enum logic {
        IDLE,
        HIGH
    } state_t;

    state_t state;

    logic        mem_op;
    logic        is_store;
    logic        is_load;
    logic        is_byte;
    logic        is_word;
    logic        misaligned;
    logic        word_start;
    logic [31:0] addr_c;
    logic [15:0] wdata_c;
    logic [1:0]  be_c;
    logic        re_c;
    logic        we_c;
    logic        stall_c;

    always_comb begin
        mem_op     = ex_valid_i & (ex_mem_read_i | ex_mem_write_i);
        is_store   = ex_mem_write_i;
        is_load    = ex_mem_read_i & ~ex_mem_write_i;
        is_byte    = (ex_size_i == 2'b00);
        is_word    = ex_size_i[1];
        misaligned = mem_op & ~is_byte & ex_alu_result_i[0];
        word_start = (state == IDLE) & mem_op & is_word & ~misaligned;

        addr_c  = '0;
        wdata_c = '0;
        be_c    = '0;
        re_c    = 1'b0;
        we_c    = 1'b0;
        stall_c = 1'b0;

        // Memory port is forced quiet while reset is held, even mid-word.
        if (!rst_i) begin
            if (state == HIGH) begin
                addr_c  = ex_alu_result_i + 32'd2;
                be_c    = 2'b11;
                re_c    = is_load;
                we_c    = is_store;
                wdata_c = is_store ? ex_store_data_i[31:16] : '0;
            end else if (mem_op && !misaligned) begin
                addr_c = ex_alu_result_i;
                re_c   = is_load;
                we_c   = is_store;
                if (is_byte) begin
                    be_c    = ex_alu_result_i[0] ? 2'b10 : 2'b01;
                    wdata_c = is_store ? {2{ex_store_data_i[7:0]}} : '0;
                end else begin
                    be_c    = 2'b11;
                    wdata_c = is_store ? ex_store_data_i[15:0] : '0;
                end
            end
            stall_c = word_start;
        end
    end

    assign mem.mem_addr_o  = addr_c;
    assign mem.mem_wdata_o = wdata_c;
    assign mem.mem_be_o    = be_c;
    assign mem.mem_re_o    = re_c;
    assign mem.mem_we_o    = we_c;
    assign stall_o         = stall_c;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state           <= IDLE;
            wb_valid_o      <= 1'b0;
            wb_data_calc_o  <= '0;
            wb_mem_to_reg_o <= 1'b0;
            wb_last_o       <= 1'b0;
            wb_rd_o         <= '0;
            wb_reg_write_o  <= 1'b0;
            misalign_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    wb_valid_o     <= ex_valid_i;
                    wb_data_calc_o <= ex_alu_result_i;
                    wb_rd_o        <= ex_rd_i;
                    misalign_o     <= misaligned;
                    if (!ex_valid_i) begin
                        wb_mem_to_reg_o <= 1'b0;
                        wb_last_o       <= 1'b0;
                        wb_reg_write_o  <= 1'b0;
                    end else if (misaligned) begin
                        wb_mem_to_reg_o <= 1'b0;
                        wb_last_o       <= 1'b1;
                        wb_reg_write_o  <= 1'b0;
                    end else if (word_start) begin
                        wb_mem_to_reg_o <= is_load;
                        wb_last_o       <= 1'b0;
                        wb_reg_write_o  <= 1'b0;
                        state           <= HIGH;
                    end else begin
                        wb_mem_to_reg_o <= mem_op & is_load;
                        wb_last_o       <= 1'b1;
                        wb_reg_write_o  <= ex_reg_write_i;
                    end
                end
                HIGH: begin
                    wb_valid_o      <= 1'b1;
                    wb_data_calc_o  <= ex_alu_result_i;
                    wb_rd_o         <= ex_rd_i;
                    wb_mem_to_reg_o <= is_load;
                    wb_last_o       <= 1'b1;
                    wb_reg_write_o  <= ex_reg_write_i;
                    misalign_o      <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
